// File: rtl/sram_controller.sv
// sram_controller: single-port asynchronous SRAM access sequencer.
// A host access runs through SETUP, STROBE (WAIT_CYCLES cycles) and HOLD, with
// registered active-low strobes. Defining SRAM_CTRL_VERIFY_EN enables a
// read-back verify pass after every write (VSETUP/VSTROBE/VHOLD) that sets the
// sticky wrErr flag on a mismatch. Without the macro, wrErr is tied to 0.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 32'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [10:0] hostAddr,
  input  logic [7:0]  hostWrData,
  output logic        ready,
  output logic [7:0]  rdData,
  output logic        rdValid,
  output logic        wrDone,
  output logic        wrErr,
  output logic [10:0] addr,
  output logic [7:0]  sramDataOut,
  input  logic [7:0]  sramDataIn,
  output logic        chipEnable,
  output logic        writeEnable,
  output logic        outputEnable
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 32'd1);

`ifdef SRAM_CTRL_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    VSETUP  = 3'd4,
    VSTROBE = 3'd5,
    VHOLD   = 3'd6
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  logic [10:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ce_q, ce_d;
  logic        we_q, we_d;
  logic        oe_q, oe_d;
  logic        ready_q, ready_d;
  logic        rd_valid_q, rd_valid_d;
  logic        wr_done_q, wr_done_d;
`ifdef SRAM_CTRL_VERIFY_EN
  logic        wr_err_q, wr_err_d;
`endif

  // Next-state, latch/counter updates and registered-output decode of the next state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
`ifdef SRAM_CTRL_VERIFY_EN
    wr_err_d   = wr_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SETUP;
          rw_d    = rw;
          addr_d  = hostAddr;
          wdata_d = hostWrData;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_LOAD;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          if (!rw_q) begin
            rd_data_d = sramDataIn;
          end else begin
            rd_data_d = rd_data_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
`ifdef SRAM_CTRL_VERIFY_EN
      HOLD: begin
        if (rw_q) begin
          state_d = VSETUP;
        end else begin
          state_d = IDLE;
        end
      end
      VSETUP: begin
        state_d = VSTROBE;
        cnt_d   = CNT_LOAD;
      end
      VSTROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = VHOLD;
          if (sramDataIn != wdata_q) begin
            wr_err_d = 1'b1;
          end else begin
            wr_err_d = wr_err_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      VHOLD: state_d = IDLE;
`else
      HOLD: state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    // Strobes and pulses are decoded from the state being entered so they register with it.
    ce_d       = 1'b1;
    we_d       = 1'b1;
    oe_d       = 1'b1;
    ready_d    = 1'b0;
    rd_valid_d = 1'b0;
    wr_done_d  = 1'b0;
    case (state_d)
      IDLE:  ready_d = 1'b1;
      SETUP: ce_d = 1'b0;
      STROBE: begin
        ce_d = 1'b0;
        if (rw_d) begin
          we_d = 1'b0;
        end else begin
          oe_d = 1'b0;
        end
      end
      HOLD: begin
        ce_d = 1'b0;
        if (!rw_d) begin
          rd_valid_d = 1'b1;
        end else begin
`ifdef SRAM_CTRL_VERIFY_EN
          wr_done_d = 1'b0;
`else
          wr_done_d = 1'b1;
`endif
        end
      end
`ifdef SRAM_CTRL_VERIFY_EN
      VSETUP: ce_d = 1'b0;
      VSTROBE: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
      end
      VHOLD: begin
        ce_d      = 1'b0;
        wr_done_d = 1'b1;
      end
`endif
      default: ready_d = 1'b0;
    endcase
  end

  // State, latches and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      rw_q       <= 1'b0;
      addr_q     <= 11'd0;
      wdata_q    <= 8'd0;
      rd_data_q  <= 8'd0;
      ce_q       <= 1'b1;
      we_q       <= 1'b1;
      oe_q       <= 1'b1;
      ready_q    <= 1'b1;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
`ifdef SRAM_CTRL_VERIFY_EN
      wr_err_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_data_q  <= rd_data_d;
      ce_q       <= ce_d;
      we_q       <= we_d;
      oe_q       <= oe_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
`ifdef SRAM_CTRL_VERIFY_EN
      wr_err_q   <= wr_err_d;
`endif
    end
  end

  assign ready        = ready_q;
  assign rdData       = rd_data_q;
  assign rdValid      = rd_valid_q;
  assign wrDone       = wr_done_q;
  assign addr         = addr_q;
  assign sramDataOut  = wdata_q;
  assign chipEnable   = ce_q;
  assign writeEnable  = we_q;
  assign outputEnable = oe_q;
`ifdef SRAM_CTRL_VERIFY_EN
  assign wrErr        = wr_err_q;
`else
  assign wrErr        = 1'b0;
`endif

endmodule
